// File: rtl/lockstep_chk_pkg.sv
// Shared types for the lockstep store checker: FSM states, error codes and
// the buffered store record.
package lockstep_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;

endpackage

// File: rtl/store_fifo.sv
// Per-core store FIFO. Pointers carry one extra bit so full and empty
// are distinguishable when the index bits match.
module store_fifo
  import lockstep_chk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  store_t data_i,
  input  logic   pop_i,
  output store_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  store_t      mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/lockstep_store_checker.sv
// Pairs the two cores' store streams in order, commits matching stores to
// the flag/result registers and latches a sticky fault on any divergence.
module lockstep_store_checker
  import lockstep_chk_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter int          MAX_SKEW    = 16,
  parameter logic [31:0] FLAG_ADDR   = 32'h0000_0100,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_0104
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        we_1_i,
  input  logic [31:0] addr_1_i,
  input  logic [31:0] data_1_i,
  input  logic        we_2_i,
  input  logic [31:0] addr_2_i,
  input  logic [31:0] data_2_i,
  output logic [31:0] mem_flag_o,
  output logic [31:0] mem_result_o,
  output logic        signal_o,
  output logic [1:0]  err_code_o,
  output logic        done_o,
  output logic [15:0] commit_cnt_o,
  output logic [1:0]  state_o
);

  localparam int SW = $clog2(MAX_SKEW + 1);

  state_e      state_q, state_d;
  err_e        err_q, err_d;
  logic [31:0] flag_q, flag_d, result_q, result_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d, signal_q, signal_d;
  logic [SW-1:0] skew_q, skew_d;

  store_t head_1, head_2;
  logic   full_1, full_2, empty_1, empty_2;
  logic   run, pair, match, mismatch, commit;
  logic   ovf_1, ovf_2, overflow, one_ne, timeout, fault;
  logic   push_1, push_2;

  assign run      = (state_q == ST_RUN);
  assign pair     = run && !empty_1 && !empty_2;
  assign match    = (head_1 == head_2);
  assign mismatch = pair && !match;
  assign commit   = pair && match;
  // A full FIFO may still accept a push when its head leaves in the same cycle.
  assign ovf_1    = run && we_1_i && full_1 && !pair;
  assign ovf_2    = run && we_2_i && full_2 && !pair;
  assign overflow = ovf_1 || ovf_2;
  assign one_ne   = run && (empty_1 != empty_2);
  assign timeout  = one_ne && (skew_q == SW'(MAX_SKEW - 1));
  assign fault    = mismatch || overflow || timeout;
  assign push_1   = run && we_1_i && !ovf_1;
  assign push_2   = run && we_2_i && !ovf_2;

  store_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_1),
    .data_i  ({addr_1_i, data_1_i}),
    .pop_i   (pair),
    .data_o  (head_1),
    .full_o  (full_1),
    .empty_o (empty_1)
  );

  store_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_2),
    .data_i  ({addr_2_i, data_2_i}),
    .pop_i   (pair),
    .data_o  (head_2),
    .full_o  (full_2),
    .empty_o (empty_2)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    flag_d   = flag_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    signal_d = signal_q;
    skew_d   = one_ne ? skew_q + 1'b1 : '0;

    if (commit) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (head_1.addr == FLAG_ADDR)   flag_d   = head_1.data;
      if (head_1.addr == RESULT_ADDR) result_d = head_1.data;
    end

    case (state_q)
      ST_IDLE: if (enable_i) state_d = ST_RUN;
      ST_RUN: begin
        if (fault) begin
          state_d  = ST_FAULT;
          signal_d = 1'b1;
          if (mismatch)      err_d = ERR_MISMATCH;
          else if (overflow) err_d = ERR_OVERFLOW;
          else               err_d = ERR_TIMEOUT;
        end else if (commit && head_1.addr == FLAG_ADDR && head_1.data != 32'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      err_q    <= ERR_NONE;
      flag_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      signal_q <= 1'b0;
      skew_q   <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      signal_q <= signal_d;
      skew_q   <= skew_d;
    end
  end

  assign mem_flag_o   = flag_q;
  assign mem_result_o = result_q;
  assign signal_o     = signal_q;
  assign err_code_o   = err_q;
  assign done_o       = done_q;
  assign commit_cnt_o = cnt_q;
  assign state_o      = state_q;

endmodule

// File: doc/lockstep_store_checker.md
# lockstep_store_checker

Consumer side of the dual-core store streams (`we_1/addr_1/data_1`, `we_2/addr_2/data_2`) that the fault-tolerant SoC exports. It buffers each core's stores independently, so the cores may run up to a bounded skew apart, and pairs them in order. It compares each pair, commits matching stores to the memory-mapped `mem_flag`/`mem_result` registers, and raises a sticky `signal_o` on any divergence. It sits beside the cores in the SoC and replaces the per-core comparison the bench currently does by eye.

## Interface
Parameters:
- `DEPTH`, 4: entries per core store FIFO; power of two, ≥2.
- `MAX_SKEW`, 16: cycles one FIFO may stay non-empty while the other is empty before a timeout fault.
- `FLAG_ADDR`, 32'h0000_0100: store address mapped to `mem_flag_o`.
- `RESULT_ADDR`, 32'h0000_0104: store address mapped to `mem_result_o`.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `enable_i` in 1: start checking; mirrors `fetch_enable_i`.
- `we_1_i` in 1: core 1 store strobe; one store per high cycle.
- `addr_1_i` in 32: core 1 store address.
- `data_1_i` in 32: core 1 store data.
- `we_2_i`, `addr_2_i`, `data_2_i`: same for core 2.
- `mem_flag_o` out 32: last committed data at `FLAG_ADDR`.
- `mem_result_o` out 32: last committed data at `RESULT_ADDR`.
- `signal_o` out 1: sticky fault indicator.
- `err_code_o` out 2: 0 none, 1 mismatch, 2 timeout, 3 overflow.
- `done_o` out 1: high once a non-zero flag has been committed.
- `commit_cnt_o` out 16: number of matched pairs; saturates at 16'hFFFF.

## Operation
- States are IDLE, RUN, DONE and FAULT.
  - IDLE → RUN when `enable_i`=1. Stores seen in IDLE are ignored.
  - RUN → FAULT on any fault condition.
  - RUN → DONE on commit of a non-zero value to `FLAG_ADDR`.
  - DONE and FAULT are absorbing until reset. `enable_i` deassertion is ignored after IDLE.
- Push (RUN only): a cycle with `we_k_i`=1 pushes {addr, data} into FIFO k.
- Pair: when both FIFOs are non-empty, both heads are popped in the same cycle and compared.
  - Addr and data equal → commit.
    - `commit_cnt_o`++.
    - If addr=`FLAG_ADDR`, `mem_flag_o`←data.
    - If addr=`RESULT_ADDR`, `mem_result_o`←data.
    - Other addresses: count only.
  - Any bit differs → FAULT with code 1. Registers are not updated.
- Timeout: a skew counter increments each RUN cycle in which exactly one FIFO is non-empty. It resets to 0 otherwise. Reaching `MAX_SKEW` → FAULT with code 2.
- Overflow: a push into a FIFO that is full and is not popped the same cycle → FAULT with code 3. A push plus pop in the same cycle on a full FIFO is legal.
- Fault priority when several conditions hit in one cycle: mismatch > overflow > timeout.
- In DONE/FAULT, pushes and pops stop; outputs hold.
- Both cores storing in the same cycle is the normal lockstep case.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - FIFOs are empty.
  - Skew counter is 0.
- Latency, lockstep store at cycle N (sampled at edge N):
  - Entries are in the FIFOs after edge N.
  - Compare/commit happens at edge N+1.
  - `mem_flag_o`/`mem_result_o`/`commit_cnt_o`/`done_o`/`signal_o` are visible after edge N+1.
- Skewed store (core 2 k cycles late): commit occurs at the edge after core 2's push.
- Throughput: one pair per cycle.
- Pointers wrap modulo `DEPTH`. Full and empty are distinguished with an extra pointer bit.
- `rst_ni` low mid-operation clears everything immediately (asynchronous), including sticky fault and `done_o`.

## Structure
- Package `lockstep_chk_pkg` holds:
  - `state_e` (IDLE/RUN/DONE/FAULT).
  - `err_e` (NONE/MISMATCH/TIMEOUT/OVERFLOW).
  - `store_t` struct {addr[31:0], data[31:0]}.
- Sub-module `store_fifo`: parameterised `DEPTH`, `store_t`-wide, with push/pop/full/empty outputs. It is instantiated twice.
- The top holds the FSM, comparator, skew counter and output registers.

## Test plan
- Lockstep: both cores store 32'd55 to `RESULT_ADDR` at cycle 3, then 32'd1 to `FLAG_ADDR` at cycle 5.
  - Expect `mem_result_o`=55 after edge 4, `mem_flag_o`=1 and `done_o`=1 after edge 6.
  - Expect `commit_cnt_o`=2 and `signal_o`=0.
- Skew: core 2 repeats core 1's three stores 3 cycles later.
  - Expect three commits, each at the edge after core 2's push, and no fault.
- Data mismatch: core 1 writes 7, core 2 writes 8, both to `RESULT_ADDR`.
  - Expect `signal_o`=1, `err_code_o`=1, `mem_result_o` unchanged.
  - Later matching stores are ignored.
- Timeout: only core 1 stores once.
  - Expect `err_code_o`=2 exactly `MAX_SKEW` cycles after the push.
- Overflow: core 1 issues `DEPTH`+1 back-to-back stores while core 2 is silent.
  - Expect `err_code_o`=3 on the (`DEPTH`+1)-th push.
- Reset mid-run: assert `rst_ni` low during FAULT.
  - Expect all outputs 0 asynchronously.
  - Then re-enable and repeat the lockstep case with the same results.
